// File: rtl/rsa_demo_core.sv
// Self-running RSA demo: encrypts MSG with (N,E), decrypts with (N,D), and reports both results and a self-check on dbg.
// Fixed latency of 4*W*W+3 edges after reset release; no inputs, so there is no backpressure.
module rsa_demo_core #(
    parameter int           W   = 12,
    parameter logic [W-1:0] N   = W'(3233),
    parameter logic [W-1:0] E   = W'(17),
    parameter logic [W-1:0] D   = W'(2753),
    parameter logic [W-1:0] MSG = W'(65)
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] dbg
);

    localparam int             AW    = W + 2;
    localparam int             IW    = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0]  LAST  = IW'(W - 1);
    localparam logic [AW-1:0]  N_EXT = AW'(N);
    localparam logic [W-1:0]   ONE   = W'(1);

    typedef enum logic [2:0] {
        LOAD_ENC,
        EXP,
        STORE_ENC,
        STORE_DEC,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic           phase_q, phase_d;
    logic           sub_q, sub_d;
    logic [W-1:0]   base_q, base_d;
    logic [W-1:0]   exp_q, exp_d;
    logic [W-1:0]   r_q, r_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [IW-1:0]  bit_q, bit_d;
    logic [IW-1:0]  cyc_q, cyc_d;
    logic [63:0]    dbg_q, dbg_d;

    // Interleaved modular multiply: r * (sub_q ? base : r), one multiplier bit per cycle, MSB first.
    logic [W-1:0]   op_b;
    logic [IW-1:0]  b_idx;
    logic           b_bit;
    logic [AW-1:0]  acc_dbl, acc_red, acc_add, acc_nx;

    always_comb begin
        op_b    = sub_q ? base_q : r_q;
        b_idx   = LAST - cyc_q;
        b_bit   = op_b[b_idx];
        acc_dbl = acc_q << 1;
        acc_red = (acc_dbl >= N_EXT) ? (acc_dbl - N_EXT) : acc_dbl;
        acc_add = acc_red + (b_bit ? AW'(r_q) : '0);
        acc_nx  = (acc_add >= N_EXT) ? (acc_add - N_EXT) : acc_add;
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        sub_d   = sub_q;
        base_d  = base_q;
        exp_d   = exp_q;
        r_d     = r_q;
        acc_d   = acc_q;
        bit_d   = bit_q;
        cyc_d   = cyc_q;
        dbg_d   = dbg_q;

        case (state_q)
            LOAD_ENC: begin
                base_d          = MSG;
                exp_d           = E;
                r_d             = ONE;
                acc_d           = '0;
                bit_d           = '0;
                cyc_d           = '0;
                sub_d           = 1'b0;
                phase_d         = 1'b0;
                dbg_d           = '0;
                dbg_d[W-1:0]    = MSG;
                state_d         = EXP;
            end
            EXP: begin
                acc_d = acc_nx;
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == LAST) begin
                    acc_d = '0;
                    cyc_d = '0;
                    if (!sub_q) begin
                        r_d   = acc_nx[W-1:0];
                        sub_d = 1'b1;
                    end else begin
                        // Multiply always runs for fixed latency; a zero exponent bit just drops its product.
                        r_d   = exp_q[W-1] ? acc_nx[W-1:0] : r_q;
                        exp_d = exp_q << 1;
                        sub_d = 1'b0;
                        bit_d = bit_q + 1'b1;
                        if (bit_q == LAST) begin
                            bit_d   = '0;
                            state_d = phase_q ? STORE_DEC : STORE_ENC;
                        end
                    end
                end
            end
            STORE_ENC: begin
                dbg_d           = '0;
                dbg_d[W-1:0]    = r_q;
                base_d          = r_q;
                exp_d           = D;
                r_d             = ONE;
                phase_d         = 1'b1;
                state_d         = EXP;
            end
            STORE_DEC: begin
                dbg_d           = '0;
                dbg_d[W-1:0]    = r_q;
                dbg_d[63]       = 1'b1;
                dbg_d[62]       = (r_q != MSG);
                state_d         = DONE;
            end
            DONE: begin
            end
            default: state_d = LOAD_ENC;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOAD_ENC;
            phase_q <= 1'b0;
            sub_q   <= 1'b0;
            base_q  <= '0;
            exp_q   <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            bit_q   <= '0;
            cyc_q   <= '0;
            dbg_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            sub_q   <= sub_d;
            base_q  <= base_d;
            exp_q   <= exp_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            bit_q   <= bit_d;
            cyc_q   <= cyc_d;
            dbg_q   <= dbg_d;
        end
    end

    assign dbg = dbg_q;

endmodule

// File: tb/tb_rsa_demo_core.sv
// Directed bench for rsa_demo_core: default keys, a wrong private key, and MSG=1 run in lockstep.
module tb_rsa_demo_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] dbg_main, dbg_wk, dbg_m1;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_wk_final;
    logic [63:0] exp_main_final = 64'h8000_0000_0000_0041;
    logic [63:0] exp_m1_final   = 64'h8000_0000_0000_0001;

    always #5 clk = ~clk;

    rsa_demo_core dut_main (.clk(clk), .rst(rst), .dbg(dbg_main));
    rsa_demo_core #(.D(12'd2752)) dut_wk (.clk(clk), .rst(rst), .dbg(dbg_wk));
    rsa_demo_core #(.MSG(12'd1)) dut_m1 (.clk(clk), .rst(rst), .dbg(dbg_m1));

    function automatic longint unsigned modexp(longint unsigned b, longint unsigned e, longint unsigned n);
        longint unsigned r = 1;
        b = b % n;
        while (e > 0) begin
            if (e[0]) r = (r * b) % n;
            b = (b * b) % n;
            e = e >> 1;
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (dbg_main !== 64'd0 || dbg_wk !== 64'd0 || dbg_m1 !== 64'd0) begin
                n_errors++;
                $display("FAIL reset_hold cycle %0d: main=%h wk=%h m1=%h, required 0", i, dbg_main, dbg_wk, dbg_m1);
            end
        end
        @(negedge clk) rst = 1'b1;
        tick();
        n_checks++;
        if (dbg_main !== 64'd65) begin
            n_errors++;
            $display("FAIL early_edge1: got %0d, required 65", dbg_main);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (dbg_main !== 64'd0 || dbg_wk !== 64'd0 || dbg_m1 !== 64'd0) begin
            n_errors++;
            $display("FAIL async_clear: main=%h wk=%h m1=%h, required 0", dbg_main, dbg_wk, dbg_m1);
        end
        repeat (3) tick();
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_encrypt;
        tick();
        n_checks++;
        if (dbg_main !== 64'd65 || dbg_wk !== 64'd65 || dbg_m1 !== 64'd1) begin
            n_errors++;
            $display("FAIL load_edge1: main=%0d wk=%0d m1=%0d, required 65 65 1", dbg_main, dbg_wk, dbg_m1);
        end
        for (int e = 2; e <= 289; e++) begin
            tick();
            n_checks++;
            if (dbg_main !== 64'd65 || dbg_wk !== 64'd65 || dbg_m1 !== 64'd1) begin
                n_errors++;
                $display("FAIL enc_hold edge %0d: main=%0d wk=%0d m1=%0d, required 65 65 1", e, dbg_main, dbg_wk, dbg_m1);
            end
        end
        tick();
        n_checks++;
        if (dbg_main !== 64'd2790 || dbg_wk !== 64'd2790 || dbg_m1 !== 64'd1) begin
            n_errors++;
            $display("FAIL ciphertext_edge290: main=%0d wk=%0d m1=%0d, required 2790 2790 1", dbg_main, dbg_wk, dbg_m1);
        end
    endtask

    task automatic test_decrypt;
        for (int e = 291; e <= 578; e++) begin
            tick();
            n_checks++;
            if (dbg_main !== 64'd2790 || dbg_wk !== 64'd2790 || dbg_m1 !== 64'd1) begin
                n_errors++;
                $display("FAIL dec_hold edge %0d: main=%0d wk=%0d m1=%0d", e, dbg_main, dbg_wk, dbg_m1);
            end
        end
        tick();
        n_checks++;
        if (dbg_main !== exp_main_final) begin
            n_errors++;
            $display("FAIL final_main: got %h, required %h", dbg_main, exp_main_final);
        end
        n_checks++;
        if (dbg_wk !== exp_wk_final) begin
            n_errors++;
            $display("FAIL final_wrong_key: got %h, required %h", dbg_wk, exp_wk_final);
        end
        n_checks++;
        if (dbg_m1 !== exp_m1_final) begin
            n_errors++;
            $display("FAIL final_msg1: got %h, required %h", dbg_m1, exp_m1_final);
        end
        for (int i = 0; i < 1000; i++) begin
            tick();
            n_checks++;
            if (dbg_main !== exp_main_final || dbg_wk !== exp_wk_final || dbg_m1 !== exp_m1_final) begin
                n_errors++;
                $display("FAIL done_stable cycle %0d: main=%h wk=%h m1=%h", i, dbg_main, dbg_wk, dbg_m1);
            end
        end
    endtask

    task automatic test_reset_mid_decrypt;
        @(negedge clk) rst = 1'b0;
        #1;
        n_checks++;
        if (dbg_main !== 64'd0) begin
            n_errors++;
            $display("FAIL done_reset_clear: got %h, required 0", dbg_main);
        end
        tick();
        @(negedge clk) rst = 1'b1;
        for (int e = 1; e <= 400; e++) begin
            tick();
            if (e == 1 || e == 290 || e == 400) begin
                n_checks++;
                if (dbg_main !== ((e == 1) ? 64'd65 : 64'd2790)) begin
                    n_errors++;
                    $display("FAIL run2 edge %0d: got %0d, required %0d", e, dbg_main, (e == 1) ? 65 : 2790);
                end
            end
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (dbg_main !== 64'd0 || dbg_wk !== 64'd0 || dbg_m1 !== 64'd0) begin
            n_errors++;
            $display("FAIL mid_decrypt_clear: main=%h wk=%h m1=%h, required 0", dbg_main, dbg_wk, dbg_m1);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (dbg_main !== 64'd0) begin
                n_errors++;
                $display("FAIL mid_decrypt_hold cycle %0d: got %h, required 0", i, dbg_main);
            end
        end
        @(negedge clk) rst = 1'b1;
        for (int e = 1; e <= 290; e++) begin
            tick();
            if (e == 1) begin
                n_checks++;
                if (dbg_main !== 64'd65 || dbg_m1 !== 64'd1) begin
                    n_errors++;
                    $display("FAIL restart_edge1: main=%0d m1=%0d, required 65 1", dbg_main, dbg_m1);
                end
            end
            if (e == 290) begin
                n_checks++;
                if (dbg_main !== 64'd2790 || dbg_wk !== 64'd2790) begin
                    n_errors++;
                    $display("FAIL restart_edge290: main=%0d wk=%0d, required 2790", dbg_main, dbg_wk);
                end
            end
        end
    endtask

    initial begin
        exp_wk_final = {2'b11, 50'd0, 12'(modexp(64'd2790, 64'd2752, 64'd3233))};
        test_reset();
        test_encrypt();
        test_decrypt();
        test_reset_mid_decrypt();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rsa_demo_core.md
Name: rsa_demo_core

Overview:
- Self-contained RSA demonstration core with no data inputs.
- After reset release it encrypts a fixed plaintext with a fixed public key, then decrypts the ciphertext with the fixed private key.
- Each stage result and a final self-check status are published on a 64-bit debug bus.
- Used as an FPGA bring-up / demo top; the only observable output is dbg.

Parameters:
W, 12, modulus/operand/exponent bit width (N < 2^W, E < 2^W, D < 2^W, W <= 62)
N, 3233, RSA modulus (61*53)
E, 17, public exponent
D, 2753, private exponent
MSG, 65, plaintext, must satisfy MSG < N

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset (0 = reset, 1 = run)
dbg  output 64  debug/status bus

Behaviour:
- Reset (rst=0, asynchronous): all registers cleared; dbg=0; state=LOAD_ENC.
  - Deasserting rst at any time, including mid-exponentiation, restarts the full sequence from LOAD_ENC; no partial results survive.
- dbg layout:
  - dbg[63] = done flag.
  - dbg[62] = mismatch error.
  - dbg[61:W] = 0.
  - dbg[W-1:0] = value.
- States: LOAD_ENC -> EXP (encrypt) -> STORE_ENC -> EXP (decrypt) -> STORE_DEC -> DONE. A phase bit distinguishes the two EXP passes.
- Edge numbering: edge k = k-th rising edge with rst=1.
- Edge 1, LOAD_ENC: base<=MSG, exp<=E, r<=1, dbg value<=MSG.
- EXP, left-to-right square-and-multiply over all W exponent bits, MSB first, leading zeros included (fixed latency):
  - Per bit, SQR sub-phase, W cycles: r <= r*r mod N.
  - Then MUL sub-phase, W cycles: t = r*base mod N; at end r <= exp[i] ? t : r.
  - Total: 2W cycles per bit, 2W*W cycles per exponentiation (288 at default).
- Modular multiply a*b mod N, interleaved shift-add, one multiplier bit per cycle, MSB first:
  - acc starts at 0.
  - Each cycle: acc = 2*acc; if acc >= N subtract N; if b bit set then acc = acc + a, and if acc >= N subtract N.
  - Internal width W+2 bits; no hardware multiplier or divider.
  - Operands are always < N, so each reduction needs at most one subtraction.
- Edge 2W*W+2 (290), STORE_ENC:
  - dbg value <= r (ciphertext).
  - base <= r, exp <= D, r <= 1.
  - Starts decryption EXP on the next edge.
- Edge 4W*W+3 (579), STORE_DEC:
  - dbg value <= r (recovered plaintext).
  - dbg[63] <= 1.
  - dbg[62] <= (r != MSG).
  - State becomes DONE.
- DONE: all registers hold; dbg stable until reset.
- dbg changes only on edges 1, 290, 579 (defaults); between those edges it holds its last value.
- Boundary cases:
  - Exponent bit = 0: the MUL sub-phase still runs its W cycles, but its result is discarded.
  - MSG = 0 or 1 gives ciphertext equal to MSG.
  - N is not required to be odd.
  - Parameter legality (MSG < N, N > 1) is not checked in hardware.

Test Plan:
- Reset held (rst=0) for 10 cycles -> dbg=0 throughout; assert rst=0 asynchronously mid-cycle and dbg clears immediately without a clock edge.
- Release rst, defaults -> edge 1: dbg=65; edges 2..289: dbg stays 65; edge 290: dbg=2790 (65^17 mod 3233).
- Continue -> edge 579: dbg[11:0]=65, dbg[63]=1, dbg[62]=0, i.e. dbg = 2^63 + 65; stable for 1000 further cycles.
- Reset asserted at edge 400 (mid-decrypt), released 3 cycles later -> dbg=0 during reset; sequence restarts with dbg=65 at the new edge 1 and 2790 at the new edge 290.
- Override D=2752 (wrong key) -> edge 579 dbg[62]=1, dbg[63]=1, value equals 2790^2752 mod 3233 as computed by a bench reference model.
- Override MSG=1, E=17, D=2753 -> dbg=1 at edges 1, 290, 579; final dbg[63]=1, dbg[62]=0.
